// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial arithmetic datapath.
//   state_e       : sequencer states (IDLE, SHIFT, DONE)
//   fs_res_t      : one full-subtractor result (difference bit, borrow-out)
//   full_sub()    : 1-bit a - b - bin, reusable by a future add/sub merge
package bit_serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic d;
    logic bout;
  } fs_res_t;

  // Borrow is produced when a < b, or when a == b and a borrow comes in.
  function automatic fs_res_t full_sub(input logic a, input logic b, input logic bin);
    fs_res_t r;
    r.d    = a ^ b ^ bin;
    r.bout = (~a & b) | (~(a ^ b) & bin);
    return r;
  endfunction

endpackage

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor: {bout_c, d_c} = a_i - b_i - bin_i.
//   a_i, b_i, bin_i : operand bits and borrow-in
//   d_c             : difference bit
//   bout_c          : borrow-out
module full_subtractor
  import bit_serial_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_c,
  output logic bout_c
);

  fs_res_t res_c;

  always_comb begin
    res_c  = full_sub(a_i, b_i, bin_i);
    d_c    = res_c.d;
    bout_c = res_c.bout;
  end

endmodule

// File: rtl/bit_serial_subtractor.sv
// Self-sequenced bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH),
// one bit per clock, LSB first, with a start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, only honoured in IDLE
//   a, b, bin  : minuend, subtrahend, borrow-in; captured on the accepted start
//   busy       : high while an operation is in flight (SHIFT and DONE)
//   done       : one-cycle pulse, diff/bout valid
//   diff, bout : registered result and borrow-out, held until the next completion
module bit_serial_subtractor
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Upper WIDTH-1 bits of the result collector; the newest bit enters at the MSB.
  logic [WIDTH-2:0] d_sh_q, d_sh_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             d_c;
  logic             brw_nxt_c;
  logic [WIDTH-1:0] d_cat_c;

  // Current bit slice of the subtraction.
  full_subtractor u_fs (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .bin_i (brw_q),
    .d_c   (d_c),
    .bout_c(brw_nxt_c)
  );

  // Collector contents after this edge's bit is shifted in.
  assign d_cat_c = {d_c, d_sh_q};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = brw_nxt_c;
        d_sh_d = d_cat_c[WIDTH-1:1];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Results only move on completion, so nothing partial is ever visible.
          diff_d  = d_cat_c;
          bout_d  = brw_nxt_c;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the state being entered.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         bin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer subtraction, wrapped to W bits.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    longint t;
    t = longint'(x) - longint'(y) - longint'(bi);
    return {(t < 0), W'(t)};
  endfunction

  // Model: an accepted request keeps the unit busy for W+1 cycles; the result
  // lands (with done) in the last of those cycles.
  int           m_left  = 0;
  logic [W-1:0] m_diff  = '0;
  logic         m_bout  = 1'b0;
  logic [W-1:0] p_diff  = '0;
  logic         p_bout  = 1'b0;
  int           m_dones = 0;
  int           d_dones = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0;
        m_diff = '0;
        m_bout = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 1) begin
          m_diff = p_diff;
          m_bout = p_bout;
          m_dones++;
        end
      end else if (start) begin
        {p_bout, p_diff} = ref_sub(a, b, bin);
        m_left = W + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_left == 1));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("bout", 32'(bout), 32'(m_bout));
      if (done) d_dones++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Issue one request, wait (bounded) for done, check literal results and timing.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                    input logic [W-1:0] exp_d, input logic exp_b, input string nm);
    int k;
    int busy_cyc;
    a = x; b = y; bin = bi; start = 1'b1;
    tick(1);
    start = 1'b0;
    k = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && k < 40) begin
      tick(1);
      k++;
      if (busy) busy_cyc++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no done within 40 cycles", nm);
    end else begin
      chk({nm, "_latency"}, 32'(k), 32'(W));
      chk({nm, "_diff"}, 32'(diff), 32'(exp_d));
      chk({nm, "_bout"}, 32'(bout), 32'(exp_b));
      tick(1);
      chk({nm, "_done_pulse"}, 32'(done), 32'd0);
      chk({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(W + 1));
      chk({nm, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int d0;
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Directed cases with hand-computed results.
    op(8'h69, 8'h34, 1'b0, 8'h35, 1'b0, "op1");
    op(8'h34, 8'h69, 1'b0, 8'hCB, 1'b1, "op2");
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "op3");
    op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "op4");
    tick(3);

    // Start re-asserted with new operands during SHIFT and DONE is ignored.
    d0 = d_dones;
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    tick(1);
    a = 8'hAA;
    tick(W);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_diff", 32'(diff), 32'h0F);
    start = 1'b0;
    tick(3);
    chk("ign_done_count", 32'(d_dones - d0), 32'd1);
    chk("ign_idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation aborts it.
    d0 = d_dones;
    a = 8'h69; b = 8'h34; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(W + 2);
    chk("abort_no_done", 32'(d_dones - d0), 32'd0);
    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "post_rst");

    // Back-to-back: start held high, fresh random operands every cycle.
    d0 = d_dones;
    start = 1'b1;
    for (int i = 0; i < 5 * (W + 2); i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      tick(1);
    end
    start = 1'b0;
    tick(W + 6);
    chk("b2b_done_count", 32'(d_dones - d0), 32'd5);

    // Random traffic with random start density.
    for (int i = 0; i < 800; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
    end
    start = 1'b0;
    tick(W + 4);
    chk("total_done_count", 32'(d_dones), 32'(m_dones));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
